// File: rtl/adder_pkg.sv
// adder_pkg: shared state encoding and default operand width for the serial adder driver
package adder_pkg;
  localparam int WIDTH_DEF = 8;
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SHIFT, S_FINAL, S_DONE} state_t;
endpackage

// File: rtl/serial_operand_driver_piso_shift.sv
// piso_shift: parallel-load, LSB-first shift register feeding one serial operand bit
module piso_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             q0
);
  logic [WIDTH-1:0] r_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_q <= '0;
    else if (load) r_q <= d;
    else if (shift) r_q <= {1'b0, r_q[WIDTH-1:1]};
  assign q0 = r_q[0];
endmodule

// File: rtl/serial_operand_driver.sv
// serial_operand_driver: sequences a carry-latch adder bit-serially and collects op_a + op_b
module serial_operand_driver
  import adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   result,
  output logic             a,
  output logic             b,
  output logic             runstop,
  input  logic             sum_in,
  input  logic             carry_in
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [WIDTH:0]  r_result;
  logic            r_a, r_b, r_runstop, r_busy, r_done;
  logic            w_load, w_shift, w_a, w_b;
  assign w_load  = (r_state == S_IDLE) && start;
  assign w_shift = (r_state == S_CLEAR) || ((r_state == S_SHIFT) && (r_cnt != LAST));
  piso_shift #(.WIDTH(WIDTH)) u_sr_a (
    .clk(clk), .reset(reset), .load(w_load), .shift(w_shift), .d(op_a), .q0(w_a)
  );
  piso_shift #(.WIDTH(WIDTH)) u_sr_b (
    .clk(clk), .reset(reset), .load(w_load), .shift(w_shift), .d(op_b), .q0(w_b)
  );
  // a/b present the bit the adder is working on; the shift registers run one bit ahead
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_result  <= '0;
      r_a       <= 1'b0;
      r_b       <= 1'b0;
      r_runstop <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_state   <= S_CLEAR;
          r_result  <= '0;
          r_runstop <= 1'b1;
          r_busy    <= 1'b1;
        end
        S_CLEAR: begin
          r_state <= S_SHIFT;
          r_a     <= w_a;
          r_b     <= w_b;
        end
        S_SHIFT: begin
          r_result[r_cnt] <= sum_in;
          if (r_cnt == LAST) begin
            r_state   <= S_FINAL;
            r_cnt     <= '0;
            r_a       <= 1'b0;
            r_b       <= 1'b0;
            r_runstop <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            r_a   <= w_a;
            r_b   <= w_b;
          end
        end
        S_FINAL: begin
          r_result[WIDTH] <= carry_in;
          r_state         <= S_DONE;
          r_busy          <= 1'b0;
          r_done          <= 1'b1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  assign busy    = r_busy;
  assign done    = r_done;
  assign result  = r_result;
  assign a       = r_a;
  assign b       = r_b;
  assign runstop = r_runstop;
endmodule
